// File: rtl/wb_read_cache.sv
// wb_read_cache: direct-mapped, byte-wide, write-through read cache for wb2spi.
// Define WB_READ_CACHE_WRITE_ALLOCATE_EN to allocate lines on write miss.
module wb_read_cache #(
    parameter int LINES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic [22:0] s_adr_i,
    input  logic        s_we_i,
    input  logic [7:0]  s_dat_i,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic        s_rty_o,
    output logic [7:0]  s_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [22:0] m_adr_o,
    output logic        m_we_o,
    output logic [7:0]  m_dat_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic [7:0]  m_dat_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 23 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [7:0]       data_q [LINES];

    logic             abort_q, abort_d;
    logic             fl_q, fl_d;
    logic             ack_d, err_d, cyc_d, we_d;
    logic [7:0]       sdat_d, mdat_d;
    logic [22:0]      adr_d;

    logic             wr_en, wr_valid, inv_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [7:0]       wr_dat;

    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] s_tag;
    logic             req, rd_hit, wr_hit, live;

    assign s_rty_o = 1'b0;
    assign m_stb_o = m_cyc_o;

    assign s_idx  = s_adr_i[IDX_W-1:0];
    assign s_tag  = s_adr_i[22:IDX_W];
    assign wr_idx = m_adr_o[IDX_W-1:0];
    assign wr_tag = m_adr_o[22:IDX_W];

    assign req    = s_cyc_i & s_stb_i & ~s_ack_o & ~s_err_o;
    assign rd_hit = valid_q[s_idx] && (tag_q[s_idx] == s_tag) && !flush_i;
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    // upstream still waiting: cycle held now and never dropped since issue
    assign live   = s_cyc_i & ~abort_q;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        sdat_d   = s_dat_o;
        cyc_d    = m_cyc_o;
        we_d     = m_we_o;
        adr_d    = m_adr_o;
        mdat_d   = m_dat_o;
        abort_d  = abort_q;
        fl_d     = fl_q;
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_dat   = m_dat_i;
        inv_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!s_we_i && rd_hit) begin
                        ack_d  = 1'b1;
                        sdat_d = data_q[s_idx];
                    end else begin
                        cyc_d   = 1'b1;
                        we_d    = s_we_i;
                        adr_d   = s_adr_i;
                        abort_d = 1'b0;
                        fl_d    = 1'b0;
                        if (s_we_i) begin
                            mdat_d  = s_dat_i;
                            state_d = WRITE;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                abort_d = abort_q | ~s_cyc_i;
                fl_d    = fl_q | flush_i;
                if (m_err_i) begin
                    err_d   = live;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (m_ack_i) begin
                    wr_en    = 1'b1;
                    wr_valid = ~fl_q;
                    ack_d    = live;
                    sdat_d   = m_dat_i;
                    cyc_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            WRITE: begin
                abort_d = abort_q | ~s_cyc_i;
                wr_dat  = m_dat_o;
                if (m_err_i) begin
                    inv_en  = 1'b1;
                    err_d   = live;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (m_ack_i) begin
`ifdef WB_READ_CACHE_WRITE_ALLOCATE_EN
                    wr_en = 1'b1;
`else
                    wr_en = wr_hit;
`endif
                    wr_valid = 1'b1;
                    ack_d    = live;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_dat_o <= '0;
            m_cyc_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            abort_q <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_ack_o <= ack_d;
            s_err_o <= err_d;
            s_dat_o <= sdat_d;
            m_cyc_o <= cyc_d;
            m_we_o  <= we_d;
            m_adr_o <= adr_d;
            m_dat_o <= mdat_d;
            abort_q <= abort_d;
            fl_q    <= fl_d;
        end
    end

    // flush is applied last so it beats a same-cycle fill or allocate
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            if (wr_en) valid_q[wr_idx] <= wr_valid;
            if (inv_en) valid_q[wr_idx] <= 1'b0;
            if (flush_i) valid_q <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_wb_read_cache.sv
// tb_wb_read_cache: directed and randomized checks of wb_read_cache
// against a line-level cache model and a behavioural SRAM slave.
module tb_wb_read_cache;

    localparam int LINES = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [22:0] s_adr_i;
    logic [7:0]  s_dat_i;
    logic        s_ack_o, s_err_o, s_rty_o;
    logic [7:0]  s_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [22:0] m_adr_o;
    logic [7:0]  m_dat_o;
    logic        m_ack_i, m_err_i;
    logic [7:0]  m_dat_i;

    int n_cmp = 0;
    int n_fail = 0;

    wb_read_cache #(.LINES(LINES)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_adr_i(s_adr_i),
        .s_we_i(s_we_i), .s_dat_i(s_dat_i), .s_ack_o(s_ack_o),
        .s_err_o(s_err_o), .s_rty_o(s_rty_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o),
        .m_we_o(m_we_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i),
        .m_err_i(m_err_i), .m_dat_i(m_dat_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // SRAM contents: slave copy and independent reference copy
    logic [7:0] sram [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37) ^ (a >> 8) ^ 8'h3C);
    endfunction

    function automatic logic [7:0] sram_rd(input int a);
        return sram.exists(a) ? sram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // downstream slave
    int          ds_total = 0;
    int          ds_delay = 0;
    bit          err_next = 0;
    logic [22:0] last_adr;
    logic        last_we;
    logic [7:0]  last_dat;

    initial begin
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && m_cyc_o && m_stb_o) begin
                ds_total++;
                last_adr = m_adr_o;
                last_we  = m_we_o;
                last_dat = m_dat_o;
                repeat (ds_delay) @(negedge clk_i);
                if (err_next) begin
                    m_err_i  = 1'b1;
                    err_next = 0;
                end else begin
                    m_ack_i = 1'b1;
                    if (last_we) sram[int'(last_adr)] = last_dat;
                    else m_dat_i = sram_rd(int'(last_adr));
                end
                @(negedge clk_i);
                m_ack_i = 1'b0;
                m_err_i = 1'b0;
            end
        end
    end

    // line-level cache model
    bit mv [LINES];
    int mt [LINES];

    function automatic int idx_of(input logic [22:0] a);
        return int'(a) % LINES;
    endfunction

    function automatic int tag_of(input logic [22:0] a);
        return int'(a) / LINES;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 0;
    endtask

    task automatic do_txn(input logic we, input logic [22:0] a,
                          input logic [7:0] d, output logic [7:0] rd,
                          output int lat, output bit ack, output bit err,
                          output int nds);
        int base;
        base = ds_total;
        ack = 0;
        err = 0;
        lat = 0;
        rd = '0;
        @(negedge clk_i);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i  = we;
        s_adr_i = a;
        s_dat_i = d;
        if (we) ref_mem[int'(a)] = d;
        while (lat < 200 && !ack && !err) begin
            @(negedge clk_i);
            lat++;
            if (s_ack_o) begin
                ack = 1;
                rd = s_dat_o;
            end
            if (s_err_o) err = 1;
        end
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        nds = ds_total - base;
    endtask

    task automatic pulse_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        flush_i = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i = 1'b0;
        s_adr_i = '0;
        s_dat_i = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o});
        end
        n_cmp++;
        if ({s_dat_o, m_adr_o, m_dat_o} !== 39'b0) begin
            n_fail++;
            $display("FAIL reset_data: s_dat=%h m_adr=%h m_dat=%h want 0",
                     s_dat_o, m_adr_o, m_dat_o);
        end
        rst_ni = 1'b1;
        ds_delay = 6;
        @(negedge clk_i);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_adr_i = 23'h000100;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (m_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_cyc: m_cyc=%b want 1", m_cyc_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({m_cyc_o, m_stb_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async: m_cyc/stb=%b want 00", {m_cyc_o, m_stb_o});
        end
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        ds_delay = 0;
    endtask

    task automatic test_read_fill();
        logic [7:0] rd;
        int lat, nds;
        bit ack, err;
        sram[23'h123] = 8'h5A;
        do_txn(1'b0, 23'h000123, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || rd !== 8'h5A || nds != 1) begin
            n_fail++;
            $display("FAIL fill_miss: ack=%0d data=%h nds=%0d want ack=1 data=5a nds=1",
                     ack, rd, nds);
        end
        do_txn(1'b0, 23'h000123, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || rd !== 8'h5A || nds != 0 || lat != 1) begin
            n_fail++;
            $display("FAIL fill_hit: data=%h nds=%0d lat=%0d want 5a 0 1", rd, nds, lat);
        end
    endtask

    task automatic test_write();
        logic [7:0] rd;
        int lat, nds;
        bit ack, err;
        do_txn(1'b1, 23'h000123, 8'hC3, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != 1 || last_we !== 1'b1 || last_adr !== 23'h123 ||
            last_dat !== 8'hC3) begin
            n_fail++;
            $display("FAIL write_down: ack=%0d nds=%0d we=%b adr=%h dat=%h want 1 1 1 123 c3",
                     ack, nds, last_we, last_adr, last_dat);
        end
        do_txn(1'b0, 23'h000123, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || rd !== 8'hC3 || nds != 0) begin
            n_fail++;
            $display("FAIL write_hit_read: data=%h nds=%0d want c3 0", rd, nds);
        end
    endtask

    task automatic test_alias();
        logic [7:0] rd;
        int lat, nds;
        bit ack, err;
        logic [22:0] seq [3];
        seq[0] = 23'h000010;
        seq[1] = 23'h000020;
        seq[2] = 23'h000010;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b0, seq[i], 8'h00, rd, lat, ack, err, nds);
            n_cmp++;
            if (!ack || nds != 1 || rd !== ref_rd(int'(seq[i]))) begin
                n_fail++;
                $display("FAIL alias_%0d: nds=%0d data=%h want 1 %h",
                         i, nds, rd, ref_rd(int'(seq[i])));
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] rd;
        int lat, nds;
        bit ack, err;
        do_txn(1'b0, 23'h000005, 8'h00, rd, lat, ack, err, nds);
        do_txn(1'b0, 23'h000005, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (nds != 0) begin
            n_fail++;
            $display("FAIL flush_prehit: nds=%0d want 0", nds);
        end
        pulse_flush();
        do_txn(1'b0, 23'h000005, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != 1 || rd !== ref_rd(5)) begin
            n_fail++;
            $display("FAIL flush_miss: nds=%0d data=%h want 1 %h", nds, rd, ref_rd(5));
        end
        ds_delay = 5;
        fork
            do_txn(1'b0, 23'h000045, 8'h00, rd, lat, ack, err, nds);
            begin
                repeat (3) @(negedge clk_i);
                flush_i = 1'b1;
                @(negedge clk_i);
                flush_i = 1'b0;
            end
        join
        ds_delay = 0;
        n_cmp++;
        if (!ack || err || nds != 1 || rd !== ref_rd(32'h45)) begin
            n_fail++;
            $display("FAIL flush_in_fill_data: ack=%0d nds=%0d data=%h want 1 1 %h",
                     ack, nds, rd, ref_rd(32'h45));
        end
        do_txn(1'b0, 23'h000045, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (nds != 1) begin
            n_fail++;
            $display("FAIL flush_in_fill_inval: nds=%0d want 1", nds);
        end
    endtask

    task automatic test_error();
        logic [7:0] rd;
        int lat, nds;
        bit ack, err;
        err_next = 1;
        do_txn(1'b0, 23'h000007, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!err || ack) begin
            n_fail++;
            $display("FAIL err_pulse: err=%0d ack=%0d want 1 0", err, ack);
        end
        @(negedge clk_i);
        n_cmp++;
        if (s_err_o !== 1'b0 || s_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_width: err=%b ack=%b want 0 0", s_err_o, s_ack_o);
        end
        do_txn(1'b0, 23'h000007, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != 1 || rd !== ref_rd(7)) begin
            n_fail++;
            $display("FAIL err_then_miss: nds=%0d data=%h want 1 %h", nds, rd, ref_rd(7));
        end
    endtask

    task automatic test_write_miss();
        logic [7:0] rd;
        int lat, nds, want;
        bit ack, err;
`ifdef WB_READ_CACHE_WRITE_ALLOCATE_EN
        want = 0;
`else
        want = 1;
`endif
        pulse_flush();
        do_txn(1'b1, 23'h000030, 8'h11, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != 1 || last_dat !== 8'h11) begin
            n_fail++;
            $display("FAIL wmiss_down: ack=%0d nds=%0d dat=%h want 1 1 11", ack, nds, last_dat);
        end
        do_txn(1'b0, 23'h000030, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != want || rd !== 8'h11) begin
            n_fail++;
            $display("FAIL wmiss_read: nds=%0d data=%h want %0d 11", nds, rd, want);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        int lat, nds, base, acks;
        bit ack, err;
        base = ds_total;
        ds_delay = 4;
        @(negedge clk_i);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_adr_i = 23'h000033;
        repeat (2) @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (s_ack_o || s_err_o) acks++;
        end
        ds_delay = 0;
        n_cmp++;
        if (acks != 0 || m_cyc_o !== 1'b0 || ds_total - base != 1) begin
            n_fail++;
            $display("FAIL abort: acks=%0d m_cyc=%b nds=%0d want 0 0 1",
                     acks, m_cyc_o, ds_total - base);
        end
        do_txn(1'b0, 23'h000033, 8'h00, rd, lat, ack, err, nds);
        n_cmp++;
        if (!ack || nds != 0 || rd !== ref_rd(32'h33)) begin
            n_fail++;
            $display("FAIL abort_filled: nds=%0d data=%h want 0 %h", nds, rd, ref_rd(32'h33));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        int lat, nds, base, acks, bad;
        bit ack, err;
        do_txn(1'b0, 23'h00000A, 8'h00, rd, lat, ack, err, nds);
        base = ds_total;
        acks = 0;
        bad = 0;
        @(negedge clk_i);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_adr_i = 23'h00000A;
        repeat (10) begin
            @(negedge clk_i);
            if (s_ack_o) begin
                acks++;
                if (s_dat_o !== ref_rd(32'hA)) bad++;
            end
        end
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        n_cmp++;
        if (acks != 5 || bad != 0 || ds_total != base) begin
            n_fail++;
            $display("FAIL back_to_back: acks=%0d bad=%0d nds=%0d want 5 0 0",
                     acks, bad, ds_total - base);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d;
        logic [22:0] a;
        int lat, nds, op, i, t;
        bit ack, err, hit;
        int tags [4];
        tags[0] = 0;
        tags[1] = 1;
        tags[2] = 2;
        tags[3] = 32'h7FFFF;
        pulse_flush();
        model_clear();
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 99));
            a = 23'((tags[$urandom_range(0, 3)] * LINES) + int'($urandom_range(0, LINES - 1)));
            i = idx_of(a);
            t = tag_of(a);
            ds_delay = int'($urandom_range(0, 3));
            hit = mv[i] && mt[i] == t;
            if (op < 5) begin
                pulse_flush();
                model_clear();
            end else if (op < 30) begin
                d = 8'($urandom);
                do_txn(1'b1, a, d, rd, lat, ack, err, nds);
                n_cmp++;
                if (!ack || err || nds != 1 || last_adr !== a || last_dat !== d ||
                    last_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_write: adr=%h ack=%0d nds=%0d dadr=%h ddat=%h want %h",
                             a, ack, nds, last_adr, last_dat, d);
                end
`ifdef WB_READ_CACHE_WRITE_ALLOCATE_EN
                mv[i] = 1;
                mt[i] = t;
`endif
            end else begin
                do_txn(1'b0, a, 8'h00, rd, lat, ack, err, nds);
                n_cmp++;
                if (!ack || err || rd !== ref_rd(int'(a)) || nds != (hit ? 0 : 1) ||
                    (hit && lat != 1)) begin
                    n_fail++;
                    $display("FAIL rnd_read: adr=%h data=%h nds=%0d lat=%0d want %h nds=%0d",
                             a, rd, nds, lat, ref_rd(int'(a)), hit ? 0 : 1);
                end
                mv[i] = 1;
                mt[i] = t;
            end
        end
        ds_delay = 0;
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_write();
        test_alias();
        test_flush();
        test_error();
        test_write_miss();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
